// File: rtl/invsqrt_iter_sched.sv
// rtl/invsqrt_iter_sched.sv - issue/recirculation scheduler for the shared Newton-Raphson inverse-sqrt pipeline
// Optional return-alignment checking: define INVSQRT_SCHED_ALIGN_CHECK_EN.
module invsqrt_iter_sched #(
    parameter int PIPE_LAT   = 4,
    parameter int ITERATIONS = 2,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [30:0]      in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             pipe_valid,
    output logic [30:0]      pipe_x,
    output logic [30:0]      pipe_y,
    input  logic             pipe_ready,
    input  logic [30:0]      pipe_x_ret,
    input  logic [30:0]      pipe_y_ret,
    output logic             out_valid,
    output logic [30:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy,
    output logic             err
);

    localparam int CNT_W = $clog2(PIPE_LAT + 1) + 1;
    localparam int BLK_W = $clog2(PIPE_LAT + 1);
    localparam logic [3:0] ITER = 4'(ITERATIONS);

    logic [PIPE_LAT-1:0] trk_v;
    logic [TAG_W-1:0]    trk_tag  [PIPE_LAT];
    logic [2:0]          trk_pass [PIPE_LAT];

    logic [TAG_W-1:0] issue_tag;
    logic [2:0]       issue_pass;
    logic [CNT_W-1:0] cnt;
    logic [BLK_W-1:0] blank_cnt;

    logic             blanking;
    logic             tail_v;
    logic [TAG_W-1:0] tail_tag;
    logic [3:0]       next_pass;
    logic             ret_ok;
    logic             recirc;
    logic             final_ret;
    logic             accept;
    logic             lost;

    assign blanking  = (blank_cnt != '0);
    assign tail_v    = trk_v[PIPE_LAT-1];
    assign tail_tag  = trk_tag[PIPE_LAT-1];
    assign next_pass = {1'b0, trk_pass[PIPE_LAT-1]} + 4'd1;

    // Blanking only matters for stale returns right after reset; the tracker is empty then anyway.
    assign ret_ok    = pipe_ready && tail_v && !blanking;
    assign recirc    = ret_ok && (next_pass < ITER);
    assign final_ret = ret_ok && !recirc;
    assign in_ready  = !rst && !recirc;
    assign accept    = in_valid && in_ready;
    assign busy      = (cnt != '0);

`ifdef INVSQRT_SCHED_ALIGN_CHECK_EN
    logic mismatch;
    assign mismatch = !blanking && (pipe_ready != tail_v);
    // A token whose return never showed up is gone; retire it so busy does not stick.
    assign lost     = !blanking && tail_v && !pipe_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (mismatch) begin
            err <= 1'b1;
        end
    end
`else
    assign lost = 1'b0;
    assign err  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trk_v <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                trk_tag[i]  <= '0;
                trk_pass[i] <= '0;
            end
        end else begin
            trk_v       <= {trk_v[PIPE_LAT-2:0], pipe_valid};
            trk_tag[0]  <= issue_tag;
            trk_pass[0] <= issue_pass;
            for (int i = 1; i < PIPE_LAT; i++) begin
                trk_tag[i]  <= trk_tag[i-1];
                trk_pass[i] <= trk_pass[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= 1'b0;
            pipe_x     <= '0;
            pipe_y     <= '0;
            issue_tag  <= '0;
            issue_pass <= '0;
        end else if (recirc) begin
            pipe_valid <= 1'b1;
            pipe_x     <= pipe_x_ret;
            pipe_y     <= pipe_y_ret;
            issue_tag  <= tail_tag;
            issue_pass <= next_pass[2:0];
        end else if (accept) begin
            pipe_valid <= 1'b1;
            pipe_x     <= in_data;
            // Magic-constant seed; the constant fits in 31 bits so modulo-2^31 subtraction is exact.
            pipe_y     <= 31'h5F3759DF - (in_data >> 1);
            issue_tag  <= in_tag;
            issue_pass <= 3'd0;
        end else begin
            pipe_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            cnt       <= '0;
            blank_cnt <= BLK_W'(PIPE_LAT);
        end else begin
            out_valid <= final_ret;
            if (final_ret) begin
                out_data <= pipe_y_ret;
                out_tag  <= tail_tag;
            end
            if (blanking) begin
                blank_cnt <= blank_cnt - 1'b1;
            end
            case ({accept, final_ret || lost})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_invsqrt_iter_sched.sv
// tb/tb_invsqrt_iter_sched.sv - scoreboard bench for invsqrt_iter_sched with a behavioural Newton pipeline
module tb_invsqrt_iter_sched;

    localparam int PIPE_LAT   = 4;
    localparam int ITERATIONS = 2;
    localparam int TAG_W      = 4;
    localparam int LATENCY    = 1 + ITERATIONS * (PIPE_LAT + 1);

`ifdef INVSQRT_SCHED_ALIGN_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [30:0]      in_data;
    logic [TAG_W-1:0] in_tag;
    logic             pipe_valid;
    logic [30:0]      pipe_x;
    logic [30:0]      pipe_y;
    logic             pipe_ready;
    logic [30:0]      pipe_x_ret;
    logic [30:0]      pipe_y_ret;
    logic             out_valid;
    logic [30:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             busy;
    logic             err;

    invsqrt_iter_sched #(.PIPE_LAT(PIPE_LAT), .ITERATIONS(ITERATIONS), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
        .pipe_valid(pipe_valid), .pipe_x(pipe_x), .pipe_y(pipe_y),
        .pipe_ready(pipe_ready), .pipe_x_ret(pipe_x_ret), .pipe_y_ret(pipe_y_ret),
        .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic real f2r(input logic [30:0] f);
        logic [63:0] d;
        d = {1'b0, 11'({3'b000, f[30:23]}) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [30:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {e[7:0], d[51:29]};
    endfunction

    function automatic logic [30:0] newton(input logic [30:0] x, input logic [30:0] y);
        real xr;
        real yr;
        xr = f2r(x);
        yr = f2r(y);
        return r2f(yr * (1.5 - 0.5 * xr * yr * yr));
    endfunction

    function automatic logic [30:0] seed_of(input logic [30:0] x);
        logic [31:0] s;
        s = 32'h5F3759DF - ({1'b0, x} >> 1);
        return s[30:0];
    endfunction

    // Behavioural Newton pipeline: not reset, so stale returns survive a scheduler reset.
    logic [PIPE_LAT-1:0] m_v = '0;
    logic [30:0]         m_x [PIPE_LAT] = '{default: '0};
    logic [30:0]         m_y [PIPE_LAT] = '{default: '0};
    logic                inject = 1'b0;

    always @(posedge clk) begin
        m_v  <= {m_v[PIPE_LAT-2:0], pipe_valid};
        m_x[0] <= pipe_x;
        m_y[0] <= newton(pipe_x, pipe_y);
        for (int i = 1; i < PIPE_LAT; i++) begin
            m_x[i] <= m_x[i-1];
            m_y[i] <= m_y[i-1];
        end
    end

    assign pipe_ready = m_v[PIPE_LAT-1] | inject;
    assign pipe_x_ret = m_x[PIPE_LAT-1];
    assign pipe_y_ret = m_y[PIPE_LAT-1];

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [30:0]      data;
        int               cyc;
    } exp_t;

    exp_t sbq[$];
    bit   blk [4096];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: in_ready arbitration, scoreboard push on accept, pop/compare on out_valid.
    initial begin
        exp_t        e;
        logic [30:0] y;
        forever begin
            @(negedge clk);
            if (!rst && in_valid) check("in_ready", in_ready, !blk[cyc & 4095]);
            if (in_valid && in_ready) begin
                y = seed_of(in_data);
                for (int k = 0; k < ITERATIONS; k++) y = newton(in_data, y);
                e.tag  = in_tag;
                e.data = y;
                e.cyc  = cyc + LATENCY;
                sbq.push_back(e);
                blk[(cyc + PIPE_LAT + 1) & 4095] = 1'b1;
            end
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("out_tag", out_tag, e.tag);
                    check("out_data", out_data, e.data);
                    check("out_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic wait_neg(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic send(input logic [30:0] d, input logic [TAG_W-1:0] t,
                        output int acc_cyc, output int stalls);
        in_valid = 1'b1;
        in_data  = d;
        in_tag   = t;
        stalls   = 0;
        acc_cyc  = -1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (in_ready) begin
                acc_cyc = cyc;
                break;
            end
            stalls++;
        end
        @(posedge clk);
        #1;
        if (acc_cyc < 0) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (sbq.size() == 0 && !busy) break;
        end
        check("drain_queue", sbq.size(), 0);
        check("drain_busy", busy, 0);
        @(posedge clk);
        #1;
    endtask

    logic [30:0] ops [4] = '{31'h40800000, 31'h40000000, 31'h41100000, 31'h3E800000};

    initial begin
        int c;
        int st;
        int st_total;
        int acc [4];
        int dd;
        logic [30:0] r;

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_tag = '0;
        repeat (3) @(negedge clk);
        check("rst_pipe_valid", pipe_valid, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_pipe_x", pipe_x, 0);
        check("rst_pipe_y", pipe_y, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (PIPE_LAT + 2) @(posedge clk);
        #1;

        // Single operand 4.0
        send(31'h40800000, 4'd3, c, st);
        in_valid = 1'b0;
        wait_neg(c + 1);
        check("t1_pipe_valid", pipe_valid, 1);
        check("t1_seed", pipe_y, 31'h3EF759DF);
        check("t1_busy", busy, 1);
        wait_neg(c + 6);
        check("t1_recirc_valid", pipe_valid, 1);
        check("t1_recirc_x", pipe_x, 31'h40800000);
        check("t1_recirc_y", pipe_y, newton(31'h40800000, 31'h3EF759DF));
        wait_neg(c + 11);
        check("t1_out_valid", out_valid, 1);
        check("t1_out_tag", out_tag, 3);
        // Two passes from the magic seed leave about 4e-6 relative error below 0.5.
        dd = int'({1'b0, out_data}) - 32'h3F000000;
        if (dd < 0) dd = -dd;
        check("t1_near_half", dd <= 128, 1);
        drain();

        // Back-to-back, tags 0..3
        for (int i = 0; i < 4; i++) begin
            send(ops[i], 4'(i), acc[i], st);
            check("t2_no_stall", st, 0);
            check("t2_consecutive", acc[i], acc[0] + i);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_neg(acc[0] + 6 + i);
            check("t2_recirc_valid", pipe_valid, 1);
            check("t2_recirc_x", pipe_x, ops[i]);
        end
        drain();

        // Continuous stream: recirculations steal exactly the first-pass return cycles
        st_total = 0;
        for (int i = 0; i < 16; i++) begin
            r = {8'($urandom_range(100, 150)), 23'($urandom)};
            send(r, 4'(i), c, st);
            st_total += st;
        end
        in_valid = 1'b0;
        check("t3_stall_total", st_total, 15);
        drain();

        // Reset mid-flight
        send(31'h40800000, 4'd5, c, st);
        send(31'h41100000, 4'd6, acc[1], st);
        send(31'h40000000, 4'd7, acc[2], st);
        in_valid = 1'b0;
        wait_neg(c + 3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sbq.delete();
        for (int i = 0; i < 4096; i++) blk[i] = 1'b0;
        @(negedge clk);
        check("t4_rst_out_valid", out_valid, 0);
        check("t4_rst_pipe_valid", pipe_valid, 0);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_out_data", out_data, 0);
        check("t4_rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("t4_no_out", out_valid, 0);
            check("t4_no_err", err, 0);
            check("t4_idle", busy, 0);
        end
        @(posedge clk);
        #1;

        // Spurious return with an empty tracker
        inject = 1'b1;
        @(negedge clk);
        check("t5_err_same_cycle", err, 0);
        @(posedge clk);
        #1;
        inject = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t5_err", err, EXP_ERR);
            check("t5_no_out", out_valid, 0);
            check("t5_busy", busy, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("t5_err_cleared", err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_final_queue", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
